// File: rtl/coin_pkg.sv
// Shared definitions for the coin-slot input conditioner: filter state
// encoding and debounce window defaults.
package coin_pkg;

  localparam int unsigned CNT_MAX_DEF = 999_999;
  localparam int unsigned CNT_MAX_SIM = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILT_DN = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_FILT_UP = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FILT_DN = ST_FILT_DN,
    HELD    = ST_HELD,
    FILT_UP = ST_FILT_UP
  } filt_state_e;

endpackage

// File: rtl/key_filter.sv
// One coin-slot channel: 2-flop synchroniser on the raw active-low switch,
// followed by a debounce FSM that emits one registered pulse per stable press.
module key_filter
  import coin_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in_n,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             sync_n_s;
  filt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  assign sync_n_s    = sync_q[1];
  assign press_pulse = press_q;

  // Synchroniser chain; resets to the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in_n};
    end
  end

  // Filter state, window counter and press event registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Next-state: any level change must persist a full window to be accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync_n_s) begin
          state_d = FILT_DN;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FILT_DN: begin
        if (sync_n_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (sync_n_s) begin
          state_d = FILT_UP;
          cnt_d   = '0;
        end else begin
          state_d = HELD;
        end
      end
      FILT_UP: begin
        if (!sync_n_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/coin_key_ctrl.sv
// Coin-slot conditioner top: two debounced channels merged by a registered
// arbiter so the vending FSM never sees both coin pulses in one cycle.
module coin_key_ctrl
  import coin_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_half_n,
  input  logic key_one_n,
  output logic po_money_half,
  output logic po_money_one
);

  logic ev_half_s, ev_one_s;
  logic pend_half_s, pend_one_s;
  logic pend_half_q, pend_half_d;
  logic pend_one_q, pend_one_d;
  logic half_q, half_d;
  logic one_q, one_d;

  key_filter #(.CNT_MAX(CNT_MAX)) u_filt_half (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in_n   (key_half_n),
    .press_pulse(ev_half_s)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_filt_one (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in_n   (key_one_n),
    .press_pulse(ev_one_s)
  );

  assign po_money_half = half_q;
  assign po_money_one  = one_q;

  // Pending flags and output pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_half_q <= 1'b0;
      pend_one_q  <= 1'b0;
      half_q      <= 1'b0;
      one_q       <= 1'b0;
    end else begin
      pend_half_q <= pend_half_d;
      pend_one_q  <= pend_one_d;
      half_q      <= half_d;
      one_q       <= one_d;
    end
  end

  // Fresh events count as pending this cycle; one-coin wins ties.
  always_comb begin
    pend_half_s = pend_half_q | ev_half_s;
    pend_one_s  = pend_one_q | ev_one_s;
    pend_half_d = pend_half_s;
    pend_one_d  = pend_one_s;
    half_d      = 1'b0;
    one_d       = 1'b0;
    if (pend_one_s) begin
      one_d      = 1'b1;
      pend_one_d = 1'b0;
    end else if (pend_half_s) begin
      half_d      = 1'b1;
      pend_half_d = 1'b0;
    end else begin
      half_d = 1'b0;
      one_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_coin_key_ctrl.sv
// Self-checking bench for coin_key_ctrl with a run-length reference model.
module tb_coin_key_ctrl;
  import coin_pkg::*;

  localparam int N = CNT_MAX_SIM;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic key_half_n = 1'b1;
  logic key_one_n = 1'b1;
  logic po_money_half, po_money_one;

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  coin_key_ctrl #(.CNT_MAX(CNT_MAX_SIM)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_half_n   (key_half_n),
    .key_one_n    (key_one_n),
    .po_money_half(po_money_half),
    .po_money_one (po_money_one)
  );

  // Reference model, index 0 = half coin, 1 = one coin.
  // A channel's debounced level flips once the sampled key has disagreed with
  // it for N+1 consecutive edges; a press seen at sampling edge e reaches the
  // arbiter at edge e+3, which then emits one-coin before half-coin.
  logic       m_pressed[2];
  int         m_run[2];
  logic [2:0] m_pipe[2];
  logic       m_pend[2];
  logic       exp_o[2];
  int         m_pulses[2];

  int edge_idx;
  int pulses[2];
  int last_edge[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pressed[c] = 1'b0;
      m_run[c]     = 0;
      m_pipe[c]    = 3'b000;
      m_pend[c]    = 1'b0;
      exp_o[c]     = 1'b0;
    end
  endtask

  task automatic model_edge(input logic kh, input logic ko);
    logic smp[2];
    logic ev[2];
    logic det;
    smp[0] = kh;
    smp[1] = ko;
    for (int c = 0; c < 2; c++) begin
      det = 1'b0;
      if ((smp[c] == 1'b0) != m_pressed[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == N + 1) begin
          m_pressed[c] = (smp[c] == 1'b0);
          m_run[c]     = 0;
          det          = m_pressed[c];
        end
      end else begin
        m_run[c] = 0;
      end
      ev[c]     = m_pipe[c][2];
      m_pipe[c] = {m_pipe[c][1:0], det};
      m_pend[c] = m_pend[c] | ev[c];
      exp_o[c]  = 1'b0;
    end
    if (m_pend[1]) begin
      exp_o[1]  = 1'b1;
      m_pend[1] = 1'b0;
    end else if (m_pend[0]) begin
      exp_o[0]  = 1'b1;
      m_pend[0] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      if (exp_o[c]) m_pulses[c] = m_pulses[c] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0b expected=%0b (edge %0d)", tag, obs, exp, edge_idx);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    edge_idx = -1;
    for (int c = 0; c < 2; c++) begin
      pulses[c]    = 0;
      last_edge[c] = -1;
      m_pulses[c]  = 0;
    end
  endtask

  task automatic tick(input logic kh, input logic ko);
    key_half_n = kh;
    key_one_n  = ko;
    @(posedge sys_clk);
    edge_idx = edge_idx + 1;
    if (sys_rst_n) model_edge(kh, ko);
    else model_reset();
    #1;
    chk("po_money_half", po_money_half, exp_o[0]);
    chk("po_money_one", po_money_one, exp_o[1]);
    chk("exclusive", po_money_half & po_money_one, 1'b0);
    if (po_money_half === 1'b1) begin
      pulses[0]    = pulses[0] + 1;
      last_edge[0] = edge_idx;
    end
    if (po_money_one === 1'b1) begin
      pulses[1]    = pulses[1] + 1;
      last_edge[1] = edge_idx;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b1);
  endtask

  int   rem[2];
  logic lvl[2];

  initial begin
    model_reset();
    start_test();

    // Power-on reset
    #2 sys_rst_n = 1'b0;
    #1;
    chk("reset_half", po_money_half, 1'b0);
    chk("reset_one", po_money_one, 1'b0);
    repeat (3) tick(1'b1, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(4);

    // Clean one-coin press, long hold, release
    start_test();
    repeat (40) tick(1'b1, 1'b0);
    idle(12);
    chk_int("clean_one_count", pulses[1], 1);
    chk_int("clean_one_edge", last_edge[1], 7);
    chk_int("clean_half_count", pulses[0], 0);

    // Half-coin bounce every 2 cycles is rejected
    start_test();
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2 == 1) ? 1'b1 : 1'b0, 1'b1);
    idle(10);
    chk_int("bounce_count", pulses[0], 0);

    // Then a stable half press
    start_test();
    repeat (10) tick(1'b0, 1'b1);
    idle(12);
    chk_int("half_press_count", pulses[0], 1);
    chk_int("half_press_edge", last_edge[0], 7);

    // Release glitch during hold, then full release and new press
    start_test();
    repeat (10) tick(1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b1);
    chk_int("glitch_count", pulses[0], 1);
    idle(8);
    start_test();
    repeat (10) tick(1'b0, 1'b1);
    idle(12);
    chk_int("repress_count", pulses[0], 1);
    chk_int("repress_edge", last_edge[0], 7);

    // Simultaneous presses
    start_test();
    repeat (10) tick(1'b0, 1'b0);
    idle(12);
    chk_int("simul_one_edge", last_edge[1], 7);
    chk_int("simul_half_edge", last_edge[0], 8);
    chk_int("simul_one_count", pulses[1], 1);
    chk_int("simul_half_count", pulses[0], 1);

    // Reset in the middle of filtering while the key stays held
    start_test();
    repeat (3) tick(1'b1, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_half", po_money_half, 1'b0);
    chk("midrst_one", po_money_one, 1'b0);
    repeat (2) tick(1'b1, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    start_test();
    repeat (15) tick(1'b1, 1'b0);
    idle(12);
    chk_int("midrst_count", pulses[1], 1);
    chk_int("midrst_edge", last_edge[1], 7);

    // Random soak: mix of sub-window bounces and stable levels
    start_test();
    for (int c = 0; c < 2; c++) begin
      rem[c] = 0;
      lvl[c] = 1'b1;
    end
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
          rem[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, N)
                                               : $urandom_range(N + 1, 3 * N);
        end
        rem[c] = rem[c] - 1;
      end
      tick(lvl[0], lvl[1]);
    end
    idle(20);
    chk_int("soak_half_count", pulses[0], m_pulses[0]);
    chk_int("soak_one_count", pulses[1], m_pulses[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
